// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall/flush controller for a five-stage in-order pipeline.
// Priority, highest first:
//   1. Memory freeze (MEM access not acknowledged).
//   2. Control redirect from EX.
//   3. Load-use interlock between EX and ID.
// It also keeps two saturating performance counters and a sticky
// memory-timeout flag.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   rs1_D, rs2_D             source register indices of the ID instruction
//   rd_E                     destination index of the EX instruction
//   is_load_E, reg_write_E   EX instruction is a load / writes the register file
//   redirect_E               EX resolved a taken branch or jump
//   mreq_M, mem_ack          MEM-stage request and memory completion
//   pc_stall                 hold the PC
//   stall_*/flush_*          per stage-register controls (IFID, IDEX, EXMEM, MEMWB)
//   mem_timeout              sticky flag: the memory wait ran too long
//   stall_cycles             saturating count of cycles with pc_stall set
//   flush_events             saturating count of redirect flushes
//   state_o                  debug view of the FSM state (RUN=0, MEM_WAIT=1)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rs1_D,
    input  logic [4:0]           rs2_D,
    input  logic [4:0]           rd_E,
    input  logic                 is_load_E,
    input  logic                 reg_write_E,
    input  logic                 redirect_E,
    input  logic                 mreq_M,
    input  logic                 mem_ack,
    output logic                 pc_stall,
    output logic                 stall_IFID,
    output logic                 flush_IFID,
    output logic                 stall_IDEX,
    output logic                 flush_IDEX,
    output logic                 stall_EXMEM,
    output logic                 flush_EXMEM,
    output logic                 stall_MEMWB,
    output logic                 flush_MEMWB,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events,
    output logic [1:0]           state_o
);

    // The wait counter is at least 8 bits wide, and wide enough to hold TIMEOUT.
    localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01
    } state_e;

    state_e                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

    logic mem_miss;
    logic redirect_act;
    logic load_use;

    // Hazard qualifiers. Each one is masked by every source of higher
    // priority. This keeps the output decode a simple one-hot choice. A
    // load into x0 never creates a dependency, so rd_E == 0 is excluded.
    assign mem_miss     = mreq_M & ~mem_ack;
    assign redirect_act = ~rst & ~mem_miss & redirect_E;
    assign load_use     = ~rst & ~mem_miss & ~redirect_E
                        & is_load_E & reg_write_E & (rd_E != 5'd0)
                        & ((rd_E == rs1_D) | (rd_E == rs2_D));

    // State register. This block also holds the wait counter, the sticky
    // timeout flag and the counters, so that reset clears them all on the
    // same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic.
    // - A miss in RUN enters MEM_WAIT with a fresh wait count.
    // - MEM_WAIT ends only on an ack. A dropped request does not end it.
    // - The timeout flag sets once the count reaches TIMEOUT. The FSM keeps
    //   waiting after that.
    // - Any illegal encoding falls back to RUN.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (mem_miss) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = RUN;
                end else if (!(&wait_cnt_q)) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
                if (wait_cnt_d >= TIMEOUT_W) begin
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Output logic. This is purely combinational from the current inputs,
    // so a freeze or a redirect acts in the same cycle with no latency.
    // While reset is high, every stage register is flushed.
    always_comb begin
        pc_stall    = 1'b0;
        stall_IFID  = 1'b0;
        flush_IFID  = 1'b0;
        stall_IDEX  = 1'b0;
        flush_IDEX  = 1'b0;
        stall_EXMEM = 1'b0;
        flush_EXMEM = 1'b0;
        stall_MEMWB = 1'b0;
        flush_MEMWB = 1'b0;
        if (rst) begin
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
            flush_MEMWB = 1'b1;
        end else if (mem_miss) begin
            pc_stall    = 1'b1;
            stall_IFID  = 1'b1;
            stall_IDEX  = 1'b1;
            stall_EXMEM = 1'b1;
            flush_MEMWB = 1'b1;
        end else if (redirect_act) begin
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            stall_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
        end
    end

    // Performance counters. Both stop at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (redirect_act && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
    assign state_o      = state_q;

endmodule
